// File: rtl/rv_src_pkg.sv
// Shared definitions for rv_lfsr_source: LFSR polynomial, lane states, seed helpers.
package rv_src_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {IDLE, OFFER, DONE} lane_state_t;

  // An all-zero Galois LFSR locks up, so a zero seed is replaced by 1.
  function automatic logic [15:0] nz16(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int k);
    return nz16(base ^ 16'(k * 32'h1F35));
  endfunction

  function automatic logic [15:0] gate_seed(input logic [15:0] base, input int k);
    return nz16(~lane_seed(base, k));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/rv_src_lane.sv
// One ready-valid source lane: FSM, data/gate LFSRs, beat counter and,
// with RV_LFSR_SOURCE_STATS_EN, a saturating stall counter.
module rv_src_lane
  import rv_src_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          MAX_TXN   = 0,
  parameter logic [15:0] DATA_SEED = 16'h0001,
  parameter logic [15:0] GATE_SEED = 16'hFFFE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [4:0]       density,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] y,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  lane_state_t      state_q, state_nxt;
  logic [15:0]      data_q, data_nxt, gate_q, gate_nxt;
  logic [31:0]      cnt_q, cnt_nxt;
  logic [WIDTH-1:0] y_q, y_nxt;
  logic             gate_hit;

  assign gate_hit = (density >= 5'd16) || ({1'b0, gate_q[3:0]} < density);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= DATA_SEED;
      gate_q  <= GATE_SEED;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_nxt;
      data_q  <= data_nxt;
      gate_q  <= gate_nxt;
      cnt_q   <= cnt_nxt;
      y_q     <= y_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    data_nxt  = data_q;
    cnt_nxt   = cnt_q;
    y_nxt     = y_q;
    gate_nxt  = en ? lfsr_step(gate_q) : gate_q;
    case (state_q)
      IDLE: begin
        if (en && gate_hit) begin
          state_nxt = OFFER;
          y_nxt     = data_q[WIDTH-1:0];
        end
      end
      OFFER: begin
        // Data advances only on accept, so the sequence ignores backpressure.
        if (ready) begin
          cnt_nxt  = cnt_q + 32'd1;
          data_nxt = lfsr_step(data_q);
          if (MAX_TXN != 0 && cnt_nxt == 32'(MAX_TXN))
            state_nxt = DONE;
          else if (en && gate_hit)
            y_nxt = data_nxt[WIDTH-1:0];
          else
            state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign valid = (state_q == OFFER);
  assign done  = (state_q == DONE);
  assign y     = y_q;

`ifdef RV_LFSR_SOURCE_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (valid && !ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: rtl/rv_lfsr_source.sv
// Multi-channel pseudo-random ready-valid source. Stall counters are built
// only when RV_LFSR_SOURCE_STATS_EN is defined.
module rv_lfsr_source
  import rv_src_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int          CHANNELS = 2,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          MAX_TXN  = 0
) (
  input  logic                         clk,
  input  logic                         i_RSTn,
  input  logic                         i_EN,
  input  logic [4:0]                   i_DENSITY,
  input  logic [CHANNELS-1:0]          i_READY,
  output logic [CHANNELS-1:0]          o_VALID,
  output logic [CHANNELS*WIDTH-1:0]    o_Y,
  output logic [CHANNELS-1:0]          o_DONE,
  output logic [31:0]                  o_TXN_CNT,
  output logic [CHANNELS*16-1:0]       o_STALL_CNT
);

  // Reset asserts asynchronously, releases on the second clk edge.
  logic [1:0] rst_sync;
  logic       rst;

  always_ff @(posedge clk or posedge i_RSTn) begin
    if (i_RSTn) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam logic [15:0] DSEED = lane_seed(SEED, k);
    localparam logic [15:0] GSEED = gate_seed(SEED, k);
    rv_src_lane #(
      .WIDTH(WIDTH), .MAX_TXN(MAX_TXN), .DATA_SEED(DSEED), .GATE_SEED(GSEED)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (i_EN),
      .density   (i_DENSITY),
      .ready     (i_READY[k]),
      .valid     (o_VALID[k]),
      .y         (o_Y[k*WIDTH +: WIDTH]),
      .done      (o_DONE[k]),
      .stall_cnt (o_STALL_CNT[k*16 +: 16])
    );
  end

  logic [31:0] acc_cnt;
  always_comb begin
    acc_cnt = '0;
    for (int k = 0; k < CHANNELS; k++)
      acc_cnt = acc_cnt + 32'(o_VALID[k] & i_READY[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_TXN_CNT <= '0;
    else     o_TXN_CNT <= o_TXN_CNT + acc_cnt;
  end

endmodule

// File: tb/tb_rv_lfsr_source.sv
// Directed bench for rv_lfsr_source (default build and MAX_TXN=3 instance).
module tb_rv_lfsr_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, en;
  logic [4:0]  dens;
  logic [1:0]  rdy;
  logic [1:0]  valid, done;
  logic [15:0] y;
  logic [31:0] cnt, stall;

  logic        rst3, en3;
  logic [4:0]  dens3;
  logic [1:0]  rdy3;
  logic [1:0]  valid3, done3;
  logic [15:0] y3;
  logic [31:0] cnt3, stall3;

  rv_lfsr_source dut (
    .clk(clk), .i_RSTn(rst), .i_EN(en), .i_DENSITY(dens), .i_READY(rdy),
    .o_VALID(valid), .o_Y(y), .o_DONE(done), .o_TXN_CNT(cnt), .o_STALL_CNT(stall)
  );

  rv_lfsr_source #(.MAX_TXN(3)) dut3 (
    .clk(clk), .i_RSTn(rst3), .i_EN(en3), .i_DENSITY(dens3), .i_READY(rdy3),
    .o_VALID(valid3), .o_Y(y3), .o_DONE(done3), .o_TXN_CNT(cnt3), .o_STALL_CNT(stall3)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rdy = 2'b00; dens = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: valid=%b want lane0 valid within 20 cycles", name, valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; rdy = 2'b11; dens = 5'd16;
    repeat (2) @(negedge clk);
    total++; if (valid !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b want 00", valid); end
    total++; if (y !== 16'h0000) begin bad++; $display("FAIL reset_y: got %h want 0000", y); end
    total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", done); end
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL reset_txn: got %0d want 0", cnt); end
    total++; if (stall !== 32'd0) begin bad++; $display("FAIL reset_stall: got %h want 0", stall); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_throughput();
    do_reset();
    dens = 5'd16; en = 1'b1; rdy = 2'b11;
    @(negedge clk);
    wait_valid("thru");
    total++; if (valid !== 2'b11) begin bad++; $display("FAIL thru_valid: got %b want 11", valid); end
    total++; if (y !== 16'hD4E1) begin bad++; $display("FAIL thru_y0: got %h want d4e1", y); end
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL thru_cnt0: got %0d want 0", cnt); end
    @(negedge clk);
    total++; if (y !== 16'hEA70) begin bad++; $display("FAIL thru_y1: got %h want ea70", y); end
    total++; if (cnt !== 32'd2) begin bad++; $display("FAIL thru_cnt1: got %0d want 2", cnt); end
    @(negedge clk);
    total++; if (y[7:0] !== 8'h38) begin bad++; $display("FAIL thru_y2: got %h want 38", y[7:0]); end
    total++; if (cnt !== 32'd4) begin bad++; $display("FAIL thru_cnt2: got %0d want 4", cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    dens = 5'd16; en = 1'b1; rdy = 2'b10;
    @(negedge clk);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      total++;
      if (valid[0] !== 1'b1 || y[7:0] !== 8'hE1) begin
        bad++; $display("FAIL stall_hold%0d: valid=%b y=%h want 1 e1", i, valid[0], y[7:0]);
      end
      @(negedge clk);
    end
    total++;
    if (valid[0] !== 1'b1 || y[7:0] !== 8'hE1) begin
      bad++; $display("FAIL stall_hold5: valid=%b y=%h want 1 e1", valid[0], y[7:0]);
    end
`ifdef RV_LFSR_SOURCE_STATS_EN
    total++; if (stall[15:0] !== 16'd5) begin bad++; $display("FAIL stall_cnt: got %0d want 5", stall[15:0]); end
`else
    total++; if (stall !== 32'd0) begin bad++; $display("FAIL stall_cnt_off: got %h want 0", stall); end
`endif
    rdy = 2'b11;
    @(negedge clk);
    total++; if (y[7:0] !== 8'h70) begin bad++; $display("FAIL stall_next: got %h want 70", y[7:0]); end
  endtask

  task automatic test_density_zero();
    int seen = 0;
    do_reset();
    dens = 5'd0; en = 1'b1; rdy = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid !== 2'b00) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL dens0_valid: got %0d valid cycles want 0", seen); end
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL dens0_txn: got %0d want 0", cnt); end
  endtask

  task automatic test_max_txn();
    int n = 0;
    rst3 = 1'b1; en3 = 1'b0; rdy3 = 2'b00; dens3 = 5'd16;
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    repeat (3) @(negedge clk);
    en3 = 1'b1; rdy3 = 2'b11;
    @(negedge clk);
    while (valid3 !== 2'b11 && n < 20) begin @(negedge clk); n++; end
    total++; if (valid3 !== 2'b11) begin bad++; $display("FAIL max_timeout: valid=%b want 11", valid3); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (valid3 !== 2'b11 || done3 !== 2'b00) begin
        bad++; $display("FAIL max_beat%0d: valid=%b done=%b want 11 00", i + 1, valid3, done3);
      end
    end
    total++; if (y3[7:0] !== 8'h38) begin bad++; $display("FAIL max_y3: got %h want 38", y3[7:0]); end
    @(negedge clk);
    total++; if (done3 !== 2'b11) begin bad++; $display("FAIL max_done: got %b want 11", done3); end
    total++; if (valid3 !== 2'b00) begin bad++; $display("FAIL max_valid: got %b want 00", valid3); end
    total++; if (cnt3 !== 32'd6) begin bad++; $display("FAIL max_txn: got %0d want 6", cnt3); end
    repeat (5) @(negedge clk);
    total++;
    if (done3 !== 2'b11 || valid3 !== 2'b00 || cnt3 !== 32'd6) begin
      bad++; $display("FAIL max_absorb: done=%b valid=%b cnt=%0d want 11 00 6", done3, valid3, cnt3);
    end
  endtask

  task automatic test_random_ready();
    logic [15:0] m [2];
    logic [7:0]  py [2];
    logic [1:0]  pv, pr;
    int acc = 0;
    do_reset();
    m[0] = 16'hACE1; m[1] = 16'hB3D4;
    pv = 2'b00; pr = 2'b00; py[0] = '0; py[1] = '0;
    dens = 5'd8; en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (valid[k]) begin
          total++;
          if (y[k*8 +: 8] !== m[k][7:0]) begin
            bad++; $display("FAIL rand_data lane%0d cyc%0d: got %h want %h", k, c, y[k*8 +: 8], m[k][7:0]);
          end
        end
        if (pv[k] && !pr[k]) begin
          total++;
          if (valid[k] !== 1'b1 || y[k*8 +: 8] !== py[k]) begin
            bad++; $display("FAIL rand_hold lane%0d cyc%0d: valid=%b y=%h want 1 %h", k, c, valid[k], y[k*8 +: 8], py[k]);
          end
        end
      end
      rdy = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        if (valid[k] && rdy[k]) begin
          m[k] = ref_step(m[k]);
          acc++;
        end
        py[k] = y[k*8 +: 8];
      end
      pv = valid; pr = rdy;
    end
    @(negedge clk);
    total++; if (cnt !== 32'(acc)) begin bad++; $display("FAIL rand_txn: got %0d want %0d", cnt, acc); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    dens = 5'd16; en = 1'b1; rdy = 2'b11;
    @(negedge clk);
    wait_valid("rmid");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (valid !== 2'b00) begin bad++; $display("FAIL rmid_valid: got %b want 00", valid); end
    total++; if (y !== 16'h0000) begin bad++; $display("FAIL rmid_y: got %h want 0000", y); end
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL rmid_txn: got %0d want 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_valid("rmid_restart");
    total++; if (y !== 16'hD4E1) begin bad++; $display("FAIL rmid_restart_y: got %h want d4e1", y); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dens = 5'd0; rdy = 2'b00;
    rst3 = 1'b1; en3 = 1'b0; dens3 = 5'd0; rdy3 = 2'b00;
    test_reset();
    test_throughput();
    test_stall();
    test_density_zero();
    test_max_txn();
    test_random_ready();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
